d_mem_copy: RTL and testbench
=============================

D_MEM_COPY -- requirements
Module: d_mem_copy

Interface
REQ-001 The block SHALL import config_pkg::* and mem_pkg::* and take DMemAddrWidth and mem_width_t (BYTE, HALFWORD, WORD) from them.
REQ-002 Parameter: LenWidth, default 16, byte-count width of len.
REQ-003 clk  input  1  the only clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 start  input  1  request a transfer; sampled only in IDLE.
REQ-006 src_addr  input  DMemAddrWidth  source byte address, sampled with start.
REQ-007 dst_addr  input  DMemAddrWidth  destination byte address, sampled with start.
REQ-008 len  input  LenWidth  byte count, sampled with start.
REQ-009 fill_mode  input  1  fill mode select, sampled with start (see Configuration).
REQ-010 fill_value  input  32  fill pattern, sampled with start.
REQ-011 busy  output  1  transfer in progress.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 mem_addr  output  DMemAddrWidth  data memory byte address.
REQ-014 mem_width  output  mem_width_t  data memory access width.
REQ-015 mem_sign_extend  output  1  tied to 0.
REQ-016 mem_data_in  output  32  write data; valid bytes right-aligned.
REQ-017 mem_write_enable  output  1  data memory write strobe.
REQ-018 mem_data_out  input  32  data memory read data, zero-extended, valid one cycle after the address is presented, provided address and width are held.

Function
REQ-019 The FSM SHALL have the states IDLE, READ, HOLD, WRITE and DONE.
REQ-020 In IDLE with start=1, the block SHALL latch src, dst, len and fill inputs; the next state SHALL be READ, or DONE when len=0.
REQ-021 The chunk width SHALL be WORD when remaining>=4, HALFWORD when remaining is 2 or 3, and BYTE when remaining is 1.
REQ-022 READ and HOLD SHALL drive mem_addr=src, mem_width=chunk and mem_write_enable=0; at the end of HOLD, mem_data_out SHALL be captured into a 32-bit register.
REQ-023 WRITE SHALL drive mem_addr=dst, mem_width=chunk, mem_data_in=captured data and mem_write_enable=1 for exactly one cycle.
REQ-024 After WRITE, the block SHALL advance src and dst by the chunk size (modulo 2^DMemAddrWidth) and decrement remaining; it SHALL go to READ if remaining>0, otherwise to DONE.
REQ-025 Misaligned src or dst SHALL be issued unchanged, because the memory handles misaligned accesses in one access.
REQ-026 DONE SHALL last one cycle with done=1 and busy=0, then return to IDLE.
REQ-027 busy SHALL be 1 in READ, HOLD and WRITE, and 0 otherwise.
REQ-028 Non-fill latency SHALL be 3 cycles per chunk plus the 1-cycle DONE state.
REQ-029 start SHALL be ignored outside IDLE, including when it coincides with DONE.
REQ-030 Overlapping ranges SHALL be copied forward, chunk by chunk, without memmove semantics.
REQ-031 Outside READ, HOLD and WRITE, mem_write_enable SHALL be 0, and mem_addr, mem_width and mem_data_in SHALL be 0, WORD and 0.

Reset
REQ-032 With reset=0 at a clock edge, the state SHALL become IDLE, and busy, done and mem_write_enable SHALL become 0; all registers SHALL be cleared.
REQ-033 A reset during any state SHALL abort the transfer with no further write; bytes already written SHALL remain.

Configuration
REQ-034 The macro D_MEM_COPY_FILL_EN SHALL compile fill mode in or out.
REQ-035 With D_MEM_COPY_FILL_EN defined and fill_mode latched as 1, each chunk SHALL consist of WRITE only (1 cycle) with mem_data_in=fill_value; src SHALL be ignored, and dst and remaining SHALL advance as in REQ-024.
REQ-036 Without D_MEM_COPY_FILL_EN, the fill_mode and fill_value ports SHALL be present but ignored, and every transfer SHALL be a copy.

Verification
REQ-037 Scenario: src=0x10, dst=0x40, len=8, memory preloaded with 0x11223344 and 0x55667788 -> two WORD writes to 0x40 and 0x44 with those values; busy for 6 cycles, then done for 1 cycle.
REQ-038 Scenario: src=0x21, dst=0x83, len=7 -> chunk widths WORD, HALFWORD, BYTE at dst 0x83, 0x87 and 0x89; 9 busy cycles; destination bytes equal the source bytes.
REQ-039 Scenario: len=0 -> no mem_write_enable; done pulses the cycle after start, and busy stays 0.
REQ-040 Scenario: start pulsed during HOLD of a len=8 transfer -> ignored; exactly 2 writes occur and 1 done pulse.
REQ-041 Scenario: reset=0 asserted during the HOLD state of the second chunk -> the next cycle is IDLE with no write; only the first word is written.
REQ-042 Scenario, with D_MEM_COPY_FILL_EN: fill_mode=1, fill_value=0xDEADBEEF, dst=0x100, len=6 -> a WORD write then a HALFWORD write of 0xBEEF at 0x104; busy for 2 cycles.

Source files
------------

// File: rtl/d_mem_copy.sv
// Copy/fill engine that moves len bytes through the data-memory port in WORD/HALFWORD/BYTE chunks.
// Fill mode is compiled in only when the macro D_MEM_COPY_FILL_EN is defined.

package config_pkg;
   localparam int DMemAddrWidth = 16;
endpackage

package mem_pkg;
   typedef enum logic [1:0] {
      BYTE     = 2'd0,
      HALFWORD = 2'd1,
      WORD     = 2'd2
   } mem_width_t;
endpackage

module d_mem_copy
   import config_pkg::*;
   import mem_pkg::*;
#(
   parameter int LenWidth = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [DMemAddrWidth-1:0] src_addr,
   input  logic [DMemAddrWidth-1:0] dst_addr,
   input  logic [LenWidth-1:0]      len,
   input  logic                     fill_mode,
   input  logic [31:0]              fill_value,
   output logic                     busy,
   output logic                     done,
   output logic [DMemAddrWidth-1:0] mem_addr,
   output mem_width_t               mem_width,
   output logic                     mem_sign_extend,
   output logic [31:0]              mem_data_in,
   output logic                     mem_write_enable,
   input  logic [31:0]              mem_data_out
);

`ifdef D_MEM_COPY_FILL_EN
   localparam logic FillEn = 1'b1;
`else
   localparam logic FillEn = 1'b0;
`endif

   typedef enum logic [2:0] {IDLE, READ, HOLD, WRITE, DONE} state_t;

   state_t                     state_q;
   logic [DMemAddrWidth-1:0]   src_q, dst_q, addr_q;
   logic [LenWidth-1:0]        rem_q;
   logic                       fill_q;
   logic [31:0]                fill_val_q;
   logic [31:0]                data_q;
   logic                       busy_q, done_q, we_q;
   mem_width_t                 width_q;

   mem_width_t                 step_w, next_w;
   logic [2:0]                 step_bytes;
   logic [DMemAddrWidth-1:0]   src_d, dst_d;
   logic [LenWidth-1:0]        rem_d;

   function automatic mem_width_t chunk_width(input logic [LenWidth-1:0] n);
      if (n >= LenWidth'(4)) return WORD;
      if (n >= LenWidth'(2)) return HALFWORD;
      return BYTE;
   endfunction

   function automatic logic [2:0] chunk_bytes(input mem_width_t w);
      case (w)
         WORD:     return 3'd4;
         HALFWORD: return 3'd2;
         default:  return 3'd1;
      endcase
   endfunction

   // Pointer/count values after the chunk currently held in rem_q completes.
   always_comb begin
      step_w     = chunk_width(rem_q);
      step_bytes = chunk_bytes(step_w);
      src_d      = src_q + DMemAddrWidth'(step_bytes);
      dst_d      = dst_q + DMemAddrWidth'(step_bytes);
      rem_d      = rem_q - LenWidth'(step_bytes);
      next_w     = chunk_width(rem_d);
   end

   // Memory-port outputs are registered, so each transition sets them for the state being entered.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= IDLE;
         src_q      <= '0;
         dst_q      <= '0;
         rem_q      <= '0;
         fill_q     <= 1'b0;
         fill_val_q <= '0;
         addr_q     <= '0;
         width_q    <= WORD;
         data_q     <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         we_q       <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  src_q      <= src_addr;
                  dst_q      <= dst_addr;
                  rem_q      <= len;
                  fill_q     <= FillEn & fill_mode;
                  fill_val_q <= fill_value;
                  if (len == '0) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else if (FillEn && fill_mode) begin
                     state_q <= WRITE;
                     busy_q  <= 1'b1;
                     addr_q  <= dst_addr;
                     width_q <= chunk_width(len);
                     data_q  <= fill_value;
                     we_q    <= 1'b1;
                  end else begin
                     state_q <= READ;
                     busy_q  <= 1'b1;
                     addr_q  <= src_addr;
                     width_q <= chunk_width(len);
                  end
               end
            end
            READ: state_q <= HOLD;
            HOLD: begin
               state_q <= WRITE;
               data_q  <= mem_data_out;
               addr_q  <= dst_q;
               we_q    <= 1'b1;
            end
            WRITE: begin
               src_q <= src_d;
               dst_q <= dst_d;
               rem_q <= rem_d;
               if (rem_d != '0) begin
                  width_q <= next_w;
                  if (fill_q) begin
                     addr_q <= dst_d;
                     data_q <= fill_val_q;
                  end else begin
                     state_q <= READ;
                     addr_q  <= src_d;
                     data_q  <= '0;
                     we_q    <= 1'b0;
                  end
               end else begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  we_q    <= 1'b0;
                  addr_q  <= '0;
                  width_q <= WORD;
                  data_q  <= '0;
               end
            end
            DONE: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy             = busy_q;
   assign done             = done_q;
   assign mem_addr         = addr_q;
   assign mem_width        = width_q;
   assign mem_sign_extend  = 1'b0;
   assign mem_data_in      = data_q;
   assign mem_write_enable = we_q;

endmodule

// File: tb/tb_d_mem_copy.sv
// Directed bench for d_mem_copy: byte-array memory model, write scoreboard and post-transfer memory compare.
// Exercises fill mode when D_MEM_COPY_FILL_EN is defined, otherwise checks that fill inputs are ignored.
module tb_d_mem_copy;
   import config_pkg::*;
   import mem_pkg::*;

`ifdef D_MEM_COPY_FILL_EN
   localparam bit FILL = 1'b1;
`else
   localparam bit FILL = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [15:0] src_addr = '0, dst_addr = '0, len = '0;
   logic        fill_mode = 1'b0;
   logic [31:0] fill_value = '0;
   logic        busy, done, mem_sign_extend, mem_write_enable;
   logic [15:0] mem_addr;
   mem_width_t  mem_width;
   logic [31:0] mem_data_in;
   logic [31:0] mem_data_out = '0;

   typedef struct packed {
      logic [15:0] addr;
      logic [1:0]  w;
      logic [31:0] data;
   } wr_t;

   wr_t        exp_q[$];
   int         total = 0;
   int         bad = 0;
   logic [7:0] mem [65536];
   logic [7:0] ref_mem [65536];

   d_mem_copy #(.LenWidth(16)) dut (
      .clk(clk), .reset(reset), .start(start),
      .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
      .fill_mode(fill_mode), .fill_value(fill_value),
      .busy(busy), .done(done),
      .mem_addr(mem_addr), .mem_width(mem_width), .mem_sign_extend(mem_sign_extend),
      .mem_data_in(mem_data_in), .mem_write_enable(mem_write_enable),
      .mem_data_out(mem_data_out)
   );

   always #5 clk = ~clk;

   function automatic int nb(input logic [1:0] w);
      return (w == 2'd2) ? 4 : (w == 2'd1) ? 2 : 1;
   endfunction

   function automatic logic [31:0] mask(input int n);
      return (n == 4) ? 32'hFFFF_FFFF : (n == 2) ? 32'h0000_FFFF : 32'h0000_00FF;
   endfunction

   function automatic logic [31:0] rd_mem(input logic [15:0] a, input int n);
      logic [31:0] v = '0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = mem[a + 16'(i)];
      return v;
   endfunction

   function automatic logic [31:0] rd_ref(input logic [15:0] a, input int n);
      logic [31:0] v = '0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[a + 16'(i)];
      return v;
   endfunction

   // Memory model: synchronous write, read data registered one cycle after the address.
   always @(posedge clk) begin
      if (mem_write_enable)
         for (int i = 0; i < nb(mem_width); i++) mem[mem_addr + 16'(i)] <= mem_data_in[8*i +: 8];
      mem_data_out <= rd_mem(mem_addr, nb(mem_width));
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic poke(input logic [15:0] a, input logic [7:0] b);
      mem[a] <= b;
      ref_mem[a] = b;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_we"}, 32'(mem_write_enable), 32'd0);
      chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
      chk({tag, "_width"}, 32'(mem_width), 32'(WORD));
      chk({tag, "_din"}, mem_data_in, 32'd0);
      chk({tag, "_sext"}, 32'(mem_sign_extend), 32'd0);
   endtask

   // Called at a negedge; drives one transfer and scoreboards every write it produces.
   task automatic run(input string tag, input logic [15:0] s, input logic [15:0] d, input logic [15:0] n,
                      input logic fm, input logic [31:0] fv, input int exp_busy,
                      input int pulse_at, input int rst_at, input int max_chunks);
      int          rem = int'(n);
      logic [15:0] sa = s, da = d;
      int          chunks = 0, sz = 0, busy_cnt = 0, writes = 0, errs = 0;
      bit          fill_eff = FILL && fm;
      bit          finished = 0, aborted = 0;
      logic [31:0] v;
      wr_t         e;
      while (rem > 0 && chunks < max_chunks) begin
         sz = (rem >= 4) ? 4 : (rem >= 2) ? 2 : 1;
         v  = fill_eff ? (fv & mask(sz)) : rd_ref(sa, sz);
         for (int i = 0; i < sz; i++) ref_mem[da + 16'(i)] = v[8*i +: 8];
         e.addr = da;
         e.w    = (sz == 4) ? 2'd2 : (sz == 2) ? 2'd1 : 2'd0;
         e.data = v;
         exp_q.push_back(e);
         sa += 16'(sz); da += 16'(sz); rem -= sz; chunks++;
      end
      if (exp_busy < 0) exp_busy = chunks * (fill_eff ? 1 : 3);

      src_addr = s; dst_addr = d; len = n; fill_mode = fm; fill_value = fv; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 300; k++) begin
         start = (k == pulse_at);
         if (busy) busy_cnt++;
         if (done) chk({tag, "_busy_in_done"}, 32'(busy), 32'd0);
         if (mem_write_enable) begin
            writes++;
            if (exp_q.size() == 0) chk({tag, "_extra_write"}, 32'(mem_addr), 32'hFFFF_FFFF);
            else begin
               e = exp_q.pop_front();
               chk({tag, "_waddr"}, 32'(mem_addr), 32'(e.addr));
               chk({tag, "_wwidth"}, 32'(mem_width), 32'(e.w));
               chk({tag, "_wdata"}, mem_data_in & mask(nb(e.w)), e.data);
            end
         end
         if (done) finished = 1;
         if (k == rst_at) begin
            reset = 1'b0;
            @(negedge clk);
            chk({tag, "_rst_busy"}, 32'(busy), 32'd0);
            chk({tag, "_rst_we"}, 32'(mem_write_enable), 32'd0);
            reset = 1'b1;
            aborted = 1;
         end
         @(negedge clk);
         if (finished || aborted) break;
      end
      start = 1'b0;
      chk({tag, "_done_seen"}, 32'(finished), 32'(!aborted));
      if (!aborted) chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
      chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      chk_idle({tag, "_after"});
      for (int i = 0; i < int'(n) + 4; i++)
         if (mem[d + 16'(i)] !== ref_mem[d + 16'(i)]) errs++;
      chk({tag, "_mem"}, 32'(errs), 32'd0);
      $display("xfer %s src=%h dst=%h len=%0d fill=%0b writes=%0d busy=%0d aborted=%0b",
               tag, s, d, n, fm, writes, busy_cnt, aborted);
   endtask

   initial begin
      logic [7:0] b;
      for (int i = 0; i < 65536; i++) begin
         b = 8'($urandom);
         poke(16'(i), b);
      end
      poke(16'h10, 8'h44); poke(16'h11, 8'h33); poke(16'h12, 8'h22); poke(16'h13, 8'h11);
      poke(16'h14, 8'h88); poke(16'h15, 8'h77); poke(16'h16, 8'h66); poke(16'h17, 8'h55);
      repeat (3) @(negedge clk);
      chk_idle("reset");
      reset = 1'b1;
      @(negedge clk);

      run("word_copy", 16'h0010, 16'h0040, 16'd8, 1'b0, 32'h0, 6, -1, -1, 99);
      chk("word0", rd_mem(16'h0040, 4), 32'h1122_3344);
      chk("word1", rd_mem(16'h0044, 4), 32'h5566_7788);
      run("misaligned", 16'h0021, 16'h0083, 16'd7, 1'b0, 32'h0, 9, -1, -1, 99);
      run("zero_len", 16'h0030, 16'h0050, 16'd0, 1'b0, 32'h0, 0, -1, -1, 99);
      run("start_in_hold", 16'h0010, 16'h0060, 16'd8, 1'b0, 32'h0, 6, 1, -1, 99);
      run("start_in_done", 16'h0010, 16'h0070, 16'd4, 1'b0, 32'h0, 3, 3, -1, 99);
      run("single_byte", 16'h0111, 16'h0222, 16'd1, 1'b0, 32'h0, 3, -1, -1, 99);
      run("overlap_fwd", 16'h0300, 16'h0302, 16'd9, 1'b0, 32'h0, -1, -1, -1, 99);
      run("addr_wrap", 16'hFFFE, 16'hFFFA, 16'd5, 1'b0, 32'h0, -1, -1, -1, 99);
      run("reset_hold", 16'h0010, 16'h0200, 16'd8, 1'b0, 32'h0, -1, -1, 4, 1);
      chk("reset_first_word", rd_mem(16'h0200, 4), 32'h1122_3344);
`ifdef D_MEM_COPY_FILL_EN
      run("fill", 16'h0500, 16'h0100, 16'd6, 1'b1, 32'hDEAD_BEEF, 2, -1, -1, 99);
      chk("fill_half", rd_mem(16'h0104, 2), 32'h0000_BEEF);
`else
      run("fill_ignored", 16'h0500, 16'h0100, 16'd6, 1'b1, 32'hDEAD_BEEF, 6, -1, -1, 99);
`endif
      for (int r = 0; r < 4; r++)
         run("random", 16'(16'h1000 + $urandom_range(0, 255)), 16'(16'h2000 + 16'h40 * r + $urandom_range(0, 3)),
             16'($urandom_range(1, 13)), 1'b0, 32'h0, -1, -1, -1, 99);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
